// File: rtl/frame_validator_pkg.sv
// Shared definitions for the BEP thermostat frame validator: field widths,
// frame framing constants, FSM encoding and the committed payload layout.
package frame_validator_pkg;

  localparam int FIELD_W = 32;
  localparam int ID_W    = 32;
  localparam int TEMP_W  = 16;
  localparam int STATE_W = 8;

  localparam int              DEF_FRAME_BITS     = 192;
  localparam logic [FIELD_W-1:0] DEF_PREAMBLE    = 32'hAAAA_AAAA;
  localparam logic [FIELD_W-1:0] DEF_CONSTANT    = 32'h0000_0000;
  localparam int              DEF_TIMEOUT_CYCLES = 20000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_CHECK   = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [TEMP_W-1:0]  room_temp;
    logic [TEMP_W-1:0]  set_temp;
    logic [STATE_W-1:0] state;
  } payload_t;

  // Eight-bit increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/frame_validator.sv
// Frame validator: counts Manchester bit strobes per transmission, checks the
// preamble/constant fields once a full frame has arrived, and either commits
// the payload to a shadow register set or counts the frame as an error.
module frame_validator
  import frame_validator_pkg::*;
#(
  parameter int                 FRAME_BITS     = DEF_FRAME_BITS,
  parameter logic [FIELD_W-1:0] PREAMBLE       = DEF_PREAMBLE,
  parameter logic [FIELD_W-1:0] CONSTANT       = DEF_CONSTANT,
  parameter int                 TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               serial_clock,
  input  logic               transmission_begin,
  input  logic [FIELD_W-1:0] preamble,
  input  logic [FIELD_W-1:0] constant,
  input  logic [ID_W-1:0]    thermostat_id,
  input  logic [TEMP_W-1:0]  room_temp,
  input  logic [TEMP_W-1:0]  set_temp,
  input  logic [STATE_W-1:0] state,
  output logic [ID_W-1:0]    id_q,
  output logic [TEMP_W-1:0]  room_temp_q,
  output logic [TEMP_W-1:0]  set_temp_q,
  output logic [STATE_W-1:0] state_q,
  output logic               frame_valid,
  output logic               frame_error,
  output logic               data_valid,
  output logic [7:0]         error_count,
  output logic               busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    LAST_BIT     = 8'(FRAME_BITS - 1);

  fsm_state_t    fsm_state, next_state;
  logic [7:0]    bit_count;
  logic [TW-1:0] timeout;
  payload_t      shadow;
  payload_t      live;
  logic          fields_ok;

  // Decisions produced by the next-state logic and consumed by the datapath.
  logic clear_counts, count_strobe, tick_timeout, do_commit, do_reject;

  assign live      = '{id: thermostat_id, room_temp: room_temp,
                       set_temp: set_temp, state: state};
  assign fields_ok = (preamble == PREAMBLE) && (constant == CONSTANT);

  assign id_q        = shadow.id;
  assign room_temp_q = shadow.room_temp;
  assign set_temp_q  = shadow.set_temp;
  assign state_q     = shadow.state;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) fsm_state <= ST_IDLE;
    else       fsm_state <= next_state;
  end

  // Next-state logic and per-cycle datapath decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    next_state   = fsm_state;
    clear_counts = 1'b0;
    count_strobe = 1'b0;
    tick_timeout = 1'b0;
    do_commit    = 1'b0;
    do_reject    = 1'b0;
    unique case (fsm_state)
      ST_IDLE: begin
        if (transmission_begin) begin
          next_state   = ST_RECEIVE;
          clear_counts = 1'b1;
        end
      end
      ST_RECEIVE: begin
        if (transmission_begin) begin
          // Re-sync: a partial frame is abandoned and counted; a coincident
          // strobe is dropped because the upstream decoder resets this cycle.
          clear_counts = 1'b1;
          do_reject    = (bit_count != 8'd0);
        end else if (serial_clock) begin
          count_strobe = 1'b1;
          if (bit_count == LAST_BIT) next_state = ST_CHECK;
        end else if (timeout == TIMEOUT_LAST) begin
          do_reject  = 1'b1;
          next_state = ST_IDLE;
        end else begin
          tick_timeout = 1'b1;
        end
      end
      ST_CHECK: begin
        do_commit = fields_ok;
        do_reject = !fields_ok;
        if (transmission_begin) begin
          next_state   = ST_RECEIVE;
          clear_counts = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Status output decoded from the current state.
  always_comb begin
    busy = (fsm_state != ST_IDLE);
  end

  // Counters, result pulses, error tally and the committed payload.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_count   <= '0;
      timeout     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      data_valid  <= 1'b0;
      error_count <= '0;
      // NOTE: the shadow payload is visible at the outputs, so it is reset
      // to zero rather than left as uninitialised storage.
      shadow      <= '0;
    end else begin
      frame_valid <= do_commit;
      frame_error <= do_reject;
      if (clear_counts) begin
        bit_count <= '0;
        timeout   <= '0;
      end else if (count_strobe) begin
        bit_count <= bit_count + 8'd1;
        timeout   <= '0;
      end else if (tick_timeout) begin
        timeout <= timeout + TW'(1);
      end
      if (do_commit) begin
        shadow     <= live;
        data_valid <= 1'b1;
      end
      if (do_reject) error_count <= sat_inc8(error_count);
    end
  end

endmodule

// File: tb/tb_frame_validator.sv
// Directed bench for frame_validator: table of whole frames with hand-computed
// results, followed by hand-written timeout, re-sync, saturation and reset
// sequences.
module tb_frame_validator;
  import frame_validator_pkg::*;

  localparam int FB = 192;
  localparam int T  = 20000;

  logic        clock = 1'b0;
  logic        reset;
  logic        serial_clock;
  logic        transmission_begin;
  logic [31:0] preamble, constant, thermostat_id;
  logic [15:0] room_temp, set_temp;
  logic [7:0]  state;
  logic [31:0] id_q;
  logic [15:0] room_temp_q, set_temp_q;
  logic [7:0]  state_q;
  logic        frame_valid, frame_error, data_valid, busy;
  logic [7:0]  error_count;

  frame_validator dut (
    .clock(clock), .reset(reset), .serial_clock(serial_clock),
    .transmission_begin(transmission_begin), .preamble(preamble),
    .constant(constant), .thermostat_id(thermostat_id),
    .room_temp(room_temp), .set_temp(set_temp), .state(state),
    .id_q(id_q), .room_temp_q(room_temp_q), .set_temp_q(set_temp_q),
    .state_q(state_q), .frame_valid(frame_valid), .frame_error(frame_error),
    .data_valid(data_valid), .error_count(error_count), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pre, con, id;
    logic [15:0] rt, st;
    logic [7:0]  stt;
    logic        exp_valid;
    logic [7:0]  exp_ec;
    logic [31:0] exp_id_q;
    logic [15:0] exp_rt_q, exp_st_q;
    logic [7:0]  exp_stt_q;
  } vec_t;

  vec_t vec [4];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_begin();
    transmission_begin = 1'b1;
    tick();
    transmission_begin = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      serial_clock = 1'b1;
      tick();
    end
    serial_clock = 1'b0;
  endtask

  task automatic set_fields(input logic [31:0] pre, input logic [31:0] con,
                            input logic [31:0] id, input logic [15:0] rt,
                            input logic [15:0] st, input logic [7:0] stt);
    preamble = pre; constant = con; thermostat_id = id;
    room_temp = rt; set_temp = st; state = stt;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec[0] = '{32'hAAAA_AAAA, 32'h0, 32'h1234_5678, 16'h00D2, 16'h00C8, 8'h03,
               1'b1, 8'd0, 32'h1234_5678, 16'h00D2, 16'h00C8, 8'h03};
    vec[1] = '{32'hAAAA_AAAB, 32'h0, 32'hDEAD_BEEF, 16'h0111, 16'h0099, 8'h07,
               1'b0, 8'd1, 32'h1234_5678, 16'h00D2, 16'h00C8, 8'h03};
    vec[2] = '{32'hAAAA_AAAA, 32'h1, 32'h0BAD_0BAD, 16'h0222, 16'h0088, 8'h01,
               1'b0, 8'd2, 32'h1234_5678, 16'h00D2, 16'h00C8, 8'h03};
    vec[3] = '{32'hAAAA_AAAA, 32'h0, 32'hCAFE_F00D, 16'h0150, 16'h0100, 8'h05,
               1'b1, 8'd2, 32'hCAFE_F00D, 16'h0150, 16'h0100, 8'h05};

    reset = 1'b1; serial_clock = 1'b0; transmission_begin = 1'b0;
    set_fields(32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 8'h0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset id_q", id_q, 32'h0);
    check("reset room_temp_q", {16'h0, room_temp_q}, 32'h0);
    check("reset frame_valid", {31'h0, frame_valid}, 32'h0);
    check("reset frame_error", {31'h0, frame_error}, 32'h0);
    check("reset data_valid", {31'h0, data_valid}, 32'h0);
    check("reset error_count", {24'h0, error_count}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);

    // Whole frames from the table.
    for (int i = 0; i < 4; i++) begin
      set_fields(vec[i].pre, vec[i].con, vec[i].id, vec[i].rt, vec[i].st, vec[i].stt);
      pulse_begin();
      strobes(FB);
      check($sformatf("vec%0d busy in check", i), {31'h0, busy}, 32'h1);
      tick();
      check($sformatf("vec%0d frame_valid", i), {31'h0, frame_valid}, {31'h0, vec[i].exp_valid});
      check($sformatf("vec%0d frame_error", i), {31'h0, frame_error}, {31'h0, !vec[i].exp_valid});
      check($sformatf("vec%0d error_count", i), {24'h0, error_count}, {24'h0, vec[i].exp_ec});
      check($sformatf("vec%0d id_q", i), id_q, vec[i].exp_id_q);
      check($sformatf("vec%0d room_temp_q", i), {16'h0, room_temp_q}, {16'h0, vec[i].exp_rt_q});
      check($sformatf("vec%0d set_temp_q", i), {16'h0, set_temp_q}, {16'h0, vec[i].exp_st_q});
      check($sformatf("vec%0d state_q", i), {24'h0, state_q}, {24'h0, vec[i].exp_stt_q});
      check($sformatf("vec%0d data_valid", i), {31'h0, data_valid}, 32'h1);
      tick();
      check($sformatf("vec%0d pulses one cycle", i), {30'h0, frame_valid, frame_error}, 32'h0);
    end

    // Timeout: 100 strobes then silence; error lands T+1 clocks after strobe 100.
    set_fields(32'hAAAA_AAAA, 32'h0, 32'h1111_1111, 16'h0AAA, 16'h0BBB, 8'h0C);
    pulse_begin();
    strobes(100);
    repeat (T - 1) tick();
    check("timeout not early", {31'h0, frame_error}, 32'h0);
    check("timeout busy before abort", {31'h0, busy}, 32'h1);
    tick();
    check("timeout frame_error", {31'h0, frame_error}, 32'h1);
    check("timeout back to idle", {31'h0, busy}, 32'h0);
    check("timeout error_count", {24'h0, error_count}, 32'd3);
    check("timeout keeps payload", {16'h0, room_temp_q}, 32'h0150);
    tick();
    check("timeout pulse one cycle", {31'h0, frame_error}, 32'h0);

    // Re-sync after 50 strobes, then a full good frame.
    set_fields(32'hAAAA_AAAA, 32'h0, 32'h2222_2222, 16'h0333, 16'h0044, 8'h02);
    pulse_begin();
    strobes(50);
    pulse_begin();
    check("resync frame_error", {31'h0, frame_error}, 32'h1);
    check("resync error_count", {24'h0, error_count}, 32'd4);
    check("resync stays busy", {31'h0, busy}, 32'h1);
    strobes(FB);
    tick();
    check("resync good frame_valid", {31'h0, frame_valid}, 32'h1);
    check("resync good no error", {31'h0, frame_error}, 32'h0);
    check("resync good room_temp_q", {16'h0, room_temp_q}, 32'h0333);
    tick();

    // Begin coincident with a strobe: that strobe must not count.
    set_fields(32'hAAAA_AAAA, 32'h0, 32'h3333_3333, 16'h0444, 16'h0045, 8'h04);
    pulse_begin();
    strobes(10);
    transmission_begin = 1'b1; serial_clock = 1'b1;
    tick();
    transmission_begin = 1'b0; serial_clock = 1'b0;
    check("coincident abort error", {31'h0, frame_error}, 32'h1);
    check("coincident error_count", {24'h0, error_count}, 32'd5);
    strobes(FB - 1);
    tick();
    check("coincident strobe not counted", {31'h0, frame_valid}, 32'h0);
    check("coincident still receiving", {31'h0, busy}, 32'h1);
    strobes(1);
    // Begin during CHECK: frame is judged, then reception restarts.
    transmission_begin = 1'b1;
    tick();
    transmission_begin = 1'b0;
    check("begin in check frame_valid", {31'h0, frame_valid}, 32'h1);
    check("begin in check room_temp_q", {16'h0, room_temp_q}, 32'h0444);
    check("begin in check to receive", {31'h0, busy}, 32'h1);
    room_temp = 16'h0555;
    strobes(FB);
    tick();
    check("after check restart frame_valid", {31'h0, frame_valid}, 32'h1);
    check("after check restart room_temp_q", {16'h0, room_temp_q}, 32'h0555);
    check("after check restart error_count", {24'h0, error_count}, 32'd5);
    tick();
    // Strobes in IDLE are ignored.
    strobes(5);
    tick();
    check("idle strobes ignored busy", {31'h0, busy}, 32'h0);
    check("idle strobes no pulses", {30'h0, frame_valid, frame_error}, 32'h0);

    // Saturation: 10 full bad frames, then short re-sync aborts.
    set_fields(32'hAAAA_AAAB, 32'h0, 32'h4444_4444, 16'h0666, 16'h0046, 8'h06);
    for (int k = 0; k < 10; k++) begin
      pulse_begin();
      strobes(FB);
      tick();
      tick();
    end
    check("ten bad frames error_count", {24'h0, error_count}, 32'd15);
    check("bad frames keep payload", {16'h0, room_temp_q}, 32'h0555);
    pulse_begin();
    strobes(1);
    for (int k = 0; k < 239; k++) begin
      pulse_begin();
      strobes(1);
    end
    check("error_count before saturation", {24'h0, error_count}, 32'd254);
    for (int k = 0; k < 11; k++) begin
      pulse_begin();
      strobes(1);
    end
    check("error_count saturated", {24'h0, error_count}, 32'd255);
    pulse_begin();
    strobes(FB);
    tick();
    check("saturated still pulses error", {31'h0, frame_error}, 32'h1);
    check("saturated holds 255", {24'h0, error_count}, 32'd255);
    tick();

    // Asynchronous reset mid-frame.
    set_fields(32'hAAAA_AAAA, 32'h0, 32'h5555_5555, 16'h0777, 16'h0047, 8'h08);
    pulse_begin();
    strobes(80);
    serial_clock = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async reset id_q", id_q, 32'h0);
    check("async reset room_temp_q", {16'h0, room_temp_q}, 32'h0);
    check("async reset data_valid", {31'h0, data_valid}, 32'h0);
    check("async reset error_count", {24'h0, error_count}, 32'h0);
    check("async reset busy", {31'h0, busy}, 32'h0);
    serial_clock = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post reset no error", {24'h0, error_count}, 32'h0);
    check("post reset idle", {31'h0, busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_validator.md
# frame_validator

Consumes the Manchester bit strobes and decoded field registers of the BEP thermostat serial decoder and decides, per transmission, whether a complete and well-formed frame was received. Good frames are committed to a shadow register set held stable for the display and output logic. Bad, truncated or stalled frames are counted and dropped. It sits directly downstream of `serial_decode`, sharing its `serial_clock` strobe and `transmission_begin` reset source.

## Interface
- `FRAME_BITS`, 192 — bit strobes per complete frame (sum of all field widths).
- `PREAMBLE`, 32'hAAAA_AAAA — required value of the preamble field.
- `CONSTANT`, 32'h0000_0000 — required value of the constant field.
- `TIMEOUT_CYCLES`, 20000 — max clocks between strobes mid-frame before abort.

- `clock` in 1 — system clock, all logic on rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `serial_clock` in 1 — one-cycle bit strobe, same signal that shifts `serial_decode`.
- `transmission_begin` in 1 — one-cycle start-of-transmission pulse.
- `preamble`, `constant` in 32 each — live decoded fields.
- `thermostat_id` in 32, `room_temp` in 16, `set_temp` in 16, `state` in 8 — live payload fields.
- `id_q` out 32, `room_temp_q` out 16, `set_temp_q` out 16, `state_q` out 8 — committed payload.
- `frame_valid` out 1 — one-cycle pulse on commit.
- `frame_error` out 1 — one-cycle pulse on rejected/aborted frame.
- `data_valid` out 1 — sticky, set by first commit.
- `error_count` out 8 — saturating rejected-frame count.
- `busy` out 1 — high in RECEIVE or CHECK.

## Operation
- States: IDLE, RECEIVE, CHECK.
- IDLE: `transmission_begin` → RECEIVE, `bit_count` := 0, `timeout` := 0. Strobes ignored.
- RECEIVE: each `serial_clock` increments `bit_count` and clears `timeout`. Otherwise `timeout` increments.
  - `bit_count` reaching `FRAME_BITS` → CHECK.
  - `timeout` == `TIMEOUT_CYCLES`−1 with no strobe → abort.
- CHECK (exactly one cycle): `preamble`==`PREAMBLE` and `constant`==`CONSTANT` → commit, else reject. Always → IDLE.
- Commit: load all `*_q` from live fields, pulse `frame_valid`, set `data_valid`.
- Reject/abort: pulse `frame_error`, `error_count` += 1 saturating at 255, `*_q` unchanged.
- `transmission_begin` in RECEIVE (re-sync):
  - If `bit_count` > 0: abort, counted as error.
  - Stay in RECEIVE, restart count at 0.
- `transmission_begin` in CHECK: evaluate the completed frame normally, then go to RECEIVE (not IDLE) with count 0.
- Simultaneous `transmission_begin` and `serial_clock`: begin wins, the strobe is not counted (`serial_decode` is reset that cycle).
- Strobes after `FRAME_BITS` (in IDLE) are ignored.
- `bit_count` is 8 bits; it never wraps because FRAME_BITS ≤ 255.

## Timing
- Reset values: state IDLE, all `*_q` 0, `frame_valid`/`frame_error`/`data_valid`/`busy` 0, `error_count` 0, counters 0.
- CHECK is entered the cycle after the final strobe. The field registers in `serial_decode` have already updated by then, so comparison uses settled values.
- `frame_valid`/`frame_error` are registered: asserted in the cycle after CHECK, for exactly 1 cycle, never both.
- `*_q` change in the same cycle `frame_valid` rises.
- Timeout abort: `frame_error` is high `TIMEOUT_CYCLES`+1 clocks after the last strobe.
- `reset` mid-frame: immediate return to reset values. No error is counted.

## Structure
- Shared include `bep_frame_defs.vh`: field widths, FRAME_BITS, PREAMBLE, CONSTANT, state encodings (2-bit localparams). Also used by `serial_decode` and top level.
- Single module. No sub-module needed. The timeout counter is inline (15 bits for default; width from `$clog2(TIMEOUT_CYCLES)`).

## Test plan
- Reset, then 192 strobes with preamble=AAAA_AAAA, constant=0, room_temp=16'h00D2 → `frame_valid` 1 cycle, `room_temp_q`=00D2, `data_valid`=1, `error_count`=0.
- Same frame with preamble=AAAA_AAAB → `frame_error` pulse, `error_count`=1, `*_q` keep previous values.
- 100 strobes, then silence → `frame_error` exactly TIMEOUT_CYCLES+1 clocks after strobe 100, state IDLE.
- `transmission_begin` after 50 strobes, then a full good frame → one `frame_error`, then one `frame_valid`. `transmission_begin` coincident with a strobe → that strobe is not counted.
- 260 bad frames → `error_count` saturates at 255. Async `reset` mid-frame → all outputs 0 within the same cycle.
